// File: rtl/jtopl_snd_ser_if.sv
// Sample/flag bundle between the JTOPL accumulator/host side and the serial audio transmitter.
// snd carries a two's-complement sample; the transmitter only moves its bits.
interface jtopl_snd_ser_if;
    logic [15:0] snd;
    logic        snd_valid;
    logic        clr;
    logic        sck;
    logic        ws;
    logic        sdo;
    logic        overrun;
    logic        underrun;

    modport master (
        output snd, snd_valid, clr,
        input  sck, ws, sdo, overrun, underrun
    );

    modport slave (
        input  snd, snd_valid, clr,
        output sck, ws, sdo, overrun, underrun
    );
endinterface

// File: rtl/jtopl_snd_ser.sv
// Serial DAC transmitter: one-deep sample hold, mono sample duplicated into a 32-bit L/R frame, MSB first.
// Define JTOPL_SER_I2S_EN for I2S one-bit-delayed data; default build is left-justified.
module jtopl_snd_ser #(
    parameter int DIV = 4
) (
    input  logic           clk,
    input  logic           rst,
    jtopl_snd_ser_if.slave io
);
    localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

    logic [7:0]  cnt_q, cnt_d;
    logic        sck_q, sck_d;
    logic        ws_q, ws_d;
    logic [4:0]  b_q, b_d;
    logic [15:0] hold_q, hold_d;
    logic        full_q, full_d;
    logic [15:0] frame_q, frame_d;
    logic [15:0] sr_q, sr_d;
    logic        ovr_q, ovr_d;
    logic        und_q, und_d;
    logic        tick_s, fall_s, start_s, load_s;

    // Bit-clock divider and slot bit position
    always_comb begin
        tick_s = (cnt_q == DIV_M1);
        fall_s = tick_s & sck_q;
        if (tick_s) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
        sck_d = sck_q ^ tick_s;
        if (fall_s) begin
            b_d = b_q + 5'd1;
        end else begin
            b_d = b_q;
        end
        start_s = fall_s & (b_d == 5'd0);
`ifdef JTOPL_SER_I2S_EN
        load_s = fall_s & ((b_d == 5'd1) | (b_d == 5'd17));
`else
        load_s = fall_s & ((b_d == 5'd0) | (b_d == 5'd16));
`endif
    end

    // Hold/frame handoff; a frame start consumes the old hold even if a new sample lands the same cycle
    always_comb begin
        hold_d  = hold_q;
        full_d  = full_q;
        frame_d = frame_q;
        ovr_d   = ovr_q & ~io.clr;
        und_d   = und_q & ~io.clr;
        if (start_s) begin
            if (full_q) begin
                frame_d = hold_q;
                full_d  = 1'b0;
            end else begin
                und_d = 1'b1;
            end
        end else begin
            frame_d = frame_q;
        end
        if (io.snd_valid) begin
            hold_d = io.snd;
            full_d = 1'b1;
            if (full_q && !start_s) begin
                ovr_d = 1'b1;
            end else begin
                ovr_d = ovr_d;
            end
        end else begin
            hold_d = hold_d;
        end
    end

    // Serializer: loading from frame_d lets a freshly consumed sample go out on the same fall
    always_comb begin
        sr_d = sr_q;
        ws_d = ws_q;
        if (fall_s) begin
            ws_d = b_d[4];
        end else begin
            ws_d = ws_q;
        end
        if (load_s) begin
            sr_d = frame_d;
        end else if (fall_s) begin
            sr_d = {sr_q[14:0], 1'b0};
        end else begin
            sr_d = sr_q;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 8'd0;
            sck_q   <= 1'b0;
            ws_q    <= 1'b0;
            b_q     <= 5'd31;
            hold_q  <= 16'h0000;
            full_q  <= 1'b0;
            frame_q <= 16'h0000;
            sr_q    <= 16'h0000;
            ovr_q   <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sck_q   <= sck_d;
            ws_q    <= ws_d;
            b_q     <= b_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            frame_q <= frame_d;
            sr_q    <= sr_d;
            ovr_q   <= ovr_d;
            und_q   <= und_d;
        end
    end

    assign io.sck      = sck_q;
    assign io.ws       = ws_q;
    assign io.sdo      = sr_q[15];
    assign io.overrun  = ovr_q;
    assign io.underrun = und_q;
endmodule

// File: tb/tb_jtopl_snd_ser.sv
// Self-checking bench for jtopl_snd_ser: flag vectors from a table, frames checked by an sck-edge monitor
// against a queue of expected samples pushed when the samples are driven.
module tb_jtopl_snd_ser;
    localparam int DIV = 4;
`ifdef JTOPL_SER_I2S_EN
    localparam logic [4:0] OFF = 5'd1;
`else
    localparam logic [4:0] OFF = 5'd0;
`endif

    typedef struct {
        int          at;
        logic        vld;
        logic [15:0] d;
        logic        clr;
        int          n_push;
        logic        exp_ovr;
        logic        exp_und;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];
    vec_t        tbl[12];

    jtopl_snd_ser_if sif();

    jtopl_snd_ser #(.DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .io  (sif.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    // Present inputs so that clk edge 'at' samples them, then return just after that edge.
    task automatic apply(input int at, input logic vld, input logic [15:0] d, input logic c);
        wait_cyc(at - 1);
        sif.snd       = d;
        sif.snd_valid = vld;
        sif.clr       = c;
        @(negedge clk);
        sif.snd_valid = 1'b0;
        sif.clr       = 1'b0;
    endtask

    task automatic do_reset(input logic send, input logic [15:0] v, input int n_push);
        logic bad;
        logic exp_sdo;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_async_outputs", {27'd0, sif.sck, sif.ws, sif.sdo, sif.overrun, sif.underrun}, 32'd0);
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if ({sif.sck, sif.ws, sif.sdo, sif.overrun, sif.underrun} != 5'd0) bad = 1'b1;
        end
        check("reset_outputs_held", {31'd0, bad}, 32'd0);
        exp_q.delete();
        repeat (n_push) exp_q.push_back(send ? v : 16'h0000);
        rst = 1'b0;
        wait_cyc(3);
        check("sck_before_first_rise", {31'd0, sif.sck}, 32'd0);
        wait_cyc(4);
        check("sck_first_rise", {31'd0, sif.sck}, 32'd1);
        if (send) apply(6, 1'b1, v, 1'b0);
        wait_cyc(7);
        check("sck_high_before_fall", {31'd0, sif.sck}, 32'd1);
        wait_cyc(8);
        exp_sdo = (OFF == 5'd0 && send) ? v[15] : 1'b0;
        check("sck_first_fall", {31'd0, sif.sck}, 32'd0);
        check("first_bit_ws_sdo", {30'd0, sif.ws, sif.sdo}, {30'd0, 1'b0, exp_sdo});
        check("first_frame_underrun", {30'd0, sif.overrun, sif.underrun}, {30'd0, 1'b0, ~send});
    endtask

    // Frame monitor: bench-side bit position advanced on every observed sck fall, sampled on sck rise
    logic        sck_prev;
    logic [4:0]  mon_b;
    logic [4:0]  mon_p;
    logic        collecting;
    logic [31:0] word, ws_word, ws_exp;
    assign mon_p = mon_b - OFF;

    always @(negedge clk) begin
        if (rst) begin
            sck_prev   <= 1'b0;
            mon_b      <= 5'd31;
            collecting <= 1'b0;
        end else begin
            sck_prev <= sif.sck;
            if (!sif.sck && sck_prev) mon_b <= mon_b + 5'd1;
            if (sif.sck && !sck_prev && (collecting || mon_p == 5'd0)) begin
                collecting             <= 1'b1;
                word[5'd31 - mon_p]    <= sif.sdo;
                ws_word[5'd31 - mon_p] <= sif.ws;
                ws_exp[5'd31 - mon_p]  <= mon_b[4];
                if (mon_p == 5'd31) begin
                    check("frame_pending", {31'd0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        check("frame_data", {word[31:1], sif.sdo}, {exp_q[0], exp_q[0]});
                        check("frame_ws", {ws_word[31:1], sif.ws}, {ws_exp[31:1], mon_b[4]});
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
        $fatal(1);
    end

    initial begin
        sif.snd       = 16'h0000;
        sif.snd_valid = 1'b0;
        sif.clr       = 1'b0;

        // at, vld, data, clr, frames pushed, expected overrun, expected underrun
        tbl[0]  = '{300,  1'b0, 16'h0000, 1'b0, 0, 1'b0, 1'b1};
        tbl[1]  = '{600,  1'b0, 16'h0000, 1'b1, 0, 1'b0, 1'b0};
        tbl[2]  = '{620,  1'b1, 16'h1234, 1'b0, 0, 1'b0, 1'b0};
        tbl[3]  = '{640,  1'b1, 16'h5678, 1'b0, 1, 1'b1, 1'b0};
        tbl[4]  = '{700,  1'b0, 16'h0000, 1'b1, 0, 1'b0, 1'b0};
        tbl[5]  = '{900,  1'b1, 16'h0F0F, 1'b0, 1, 1'b0, 1'b0};
        tbl[6]  = '{1032, 1'b1, 16'hAAAA, 1'b0, 2, 1'b0, 1'b0};
        tbl[7]  = '{1300, 1'b0, 16'h0000, 1'b0, 0, 1'b0, 1'b0};
        tbl[8]  = '{1544, 1'b1, 16'hBBBB, 1'b0, 1, 1'b0, 1'b1};
        tbl[9]  = '{1600, 1'b0, 16'h0000, 1'b1, 0, 1'b0, 1'b0};
        tbl[10] = '{1810, 1'b1, 16'h8000, 1'b0, 1, 1'b0, 1'b0};
        tbl[11] = '{2080, 1'b0, 16'h0000, 1'b0, 0, 1'b0, 1'b0};

        // Sample 8001 ahead of frame 0, then repeated for two starved frames
        do_reset(1'b1, 16'h8001, 3);

        for (int i = 0; i < 12; i++) begin
            repeat (tbl[i].n_push) exp_q.push_back(tbl[i].d);
            apply(tbl[i].at, tbl[i].vld, tbl[i].d, tbl[i].clr);
            check($sformatf("flags_vec%0d", i), {30'd0, sif.overrun, sif.underrun},
                  {30'd0, tbl[i].exp_ovr, tbl[i].exp_und});
        end

        wait_cyc(2325);
        check("queue_drained_run1", exp_q.size(), 32'd0);

        // Mid-frame reset with a pending sample that must be discarded
        apply(2330, 1'b1, 16'h7777, 1'b0);
        wait_cyc(2340);
        do_reset(1'b0, 16'h0000, 1);

        exp_q.push_back(16'h1357);
        apply(100, 1'b1, 16'h1357, 1'b0);
        check("flags_after_reset", {30'd0, sif.overrun, sif.underrun}, {30'd0, 1'b0, 1'b1});
        wait_cyc(540);
        check("queue_drained_run2", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
